// File: rtl/tc_multi_if.sv
// Bus bundle for the multi-channel timer/counter: byte-enabled MMIO write,
// combinational read data, combined IRQ and per-channel IRQ vector.
interface tc_multi_if #(
  parameter int NCH = 2
);
  logic [3:0]     byteen;
  logic [31:0]    addr;
  logic [31:0]    wdata;
  logic [31:0]    rdata;
  logic           IRQ;
  logic [NCH-1:0] irq_vec;

  modport master (
    output byteen, addr, wdata,
    input  rdata, IRQ, irq_vec
  );

  modport slave (
    input  byteen, addr, wdata,
    output rdata, IRQ, irq_vec
  );
endinterface

// File: rtl/tc_multi.sv
// NCH independent prescaled down-counters (one-shot / auto-reload), W1C IP.
// Ports: clk, RESET (sync, active-high), bus (tc_multi_if.slave).
module tc_multi #(
  parameter int NCH   = 2,
  parameter int CNT_W = 32
) (
  input logic       clk,
  input logic       RESET,
  tc_multi_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2
  } st_t;

  logic           we;
  logic [3:0]     ch;
  logic [1:0]     rg;
  logic [31:0]    bmask;
  logic [31:0]    rd [NCH];
  logic [NCH-1:0] vec;
  logic           unused_bits;

  assign we = |bus.byteen;
  assign ch = bus.addr[7:4];
  assign rg = bus.addr[3:2];

  assign bmask = {{8{bus.byteen[3]}},
                  {8{bus.byteen[2]}},
                  {8{bus.byteen[1]}},
                  {8{bus.byteen[0]}}};

  assign unused_bits = ^{bus.addr[31:8],
                         bus.addr[1:0],
                         bus.wdata, bmask};

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    st_t              st;
    logic             en;
    logic             mode;
    logic             im;
    logic             ip;
    logic [7:0]       psc;
    logic [7:0]       pcnt;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] pnext;
    logic             wr;

    assign wr = we && (ch == 4'(k));

    assign pnext =
      (preset & ~bmask[CNT_W-1:0]) |
      (bus.wdata[CNT_W-1:0] & bmask[CNT_W-1:0]);

    // A write to this channel freezes its FSM, prescaler and count.
    always_ff @(posedge clk) begin
      if (RESET) begin
        st     <= IDLE;
        en     <= 1'b0;
        mode   <= 1'b0;
        im     <= 1'b0;
        ip     <= 1'b0;
        psc    <= '0;
        pcnt   <= '0;
        preset <= '0;
        count  <= '0;
      end else if (wr) begin
        if (rg == 2'd0) begin
          if (bus.byteen[0]) begin
            en   <= bus.wdata[0];
            mode <= bus.wdata[1];
            im   <= bus.wdata[3];
            if (bus.wdata[4]) ip <= 1'b0;
          end
          if (bus.byteen[1]) psc <= bus.wdata[15:8];
        end
        if (rg == 2'd1) preset <= pnext;
      end else begin
        unique case (st)
          IDLE: begin
            if (en) st <= LOAD;
          end
          LOAD: begin
            count <= preset;
            pcnt  <= '0;
            st    <= CNT;
          end
          CNT: begin
            if (!en) begin
              st <= IDLE;
            end else if (pcnt != psc) begin
              pcnt <= pcnt + 8'd1;
            end else begin
              pcnt <= '0;
              if (count > CNT_W'(1)) begin
                count <= count - CNT_W'(1);
              end else begin
                ip <= 1'b1;
                if (mode) begin
                  count <= preset;
                end else begin
                  count <= '0;
                  en    <= 1'b0;
                  st    <= IDLE;
                end
              end
            end
          end
          default: st <= IDLE;
        endcase
      end
    end

    always_comb begin
      rd[k] = '0;
      unique case (1'b1)
        rg == 2'd0:
          rd[k] = {16'b0, psc, 3'b0,
                   ip, im, 1'b0, mode, en};
        rg == 2'd1: rd[k] = 32'(preset);
        rg == 2'd2: rd[k] = 32'(count);
        default:    rd[k] = '0;
      endcase
    end

    assign vec[k] = ip & im;
  end

  always_comb begin
    bus.rdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch == 4'(k)) bus.rdata = rd[k];
    end
  end

  assign bus.irq_vec = vec;
  assign bus.IRQ     = |vec;

endmodule
